uart_rx_frame: RTL and testbench

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_rx_frame.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver that assembles 32 bytes into a 256-bit frame, first byte in the MSBs.
// Optional idle timeout abandons a partial frame when UART_RX_TIMEOUT_EN is defined.
module uart_rx_frame #(
  parameter int unsigned UART_BPS     = 'd9600,
  parameter int unsigned CLK_FREQ     = 'd50_000_000,
  parameter int unsigned TIMEOUT_BITS = 'd20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx,
  output logic [255:0] po_data,
  output logic         po_flag,
  output logic         frame_err
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned CW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(BAUD_CNT_MAX / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic           r_rx_s1;
  logic           r_rx_s2;
  logic           r_rx_d;
  logic [CW-1:0]  r_baud_cnt;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic [5:0]     r_byte_cnt;
  logic [255:0]   r_asm;
  logic [255:0]   r_po_data;
  logic           r_po_flag;
  logic           r_frame_err;
  logic           w_rx;
  logic           w_fall;
  logic           w_mid;
  logic [255:0]   w_asm_next;

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_LIMIT = TIMEOUT_BITS * BAUD_CNT_MAX;
  localparam int unsigned IW = $clog2(TIMEOUT_LIMIT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_LIMIT - 1);
  logic [IW-1:0]  r_idle_cnt;
  logic           w_timeout;
`endif

  assign w_rx   = r_rx_s2;
  assign w_fall = r_rx_d & ~r_rx_s2;
  assign w_mid  = (r_state != IDLE) && (r_baud_cnt == CNT_MID);

  // Byte k lands at [255-8k -: 8]; {~k,3'b000} is 248-8k for a 5-bit k.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{~r_byte_cnt[4:0], 3'b000} +: 8] = r_shift;
  end

`ifdef UART_RX_TIMEOUT_EN
  assign w_timeout = (r_state == IDLE) && (r_byte_cnt != '0) && !w_fall &&
                     (r_idle_cnt == IDLE_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_next_state = START;
      START:   if (w_mid) w_next_state = w_rx ? IDLE : DATA;
      DATA:    if (w_mid && (r_bit_cnt == 3'd7)) w_next_state = STOP;
      STOP:    if (w_mid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_baud_cnt <= '0;
    end else if (r_baud_cnt == CNT_LAST) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_mid) begin
      if (r_state == START) begin
        r_bit_cnt <= '0;
      end else if (r_state == DATA) begin
        r_shift   <= {w_rx, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt  <= '0;
      r_asm       <= '0;
      r_po_data   <= '0;
      r_po_flag   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_po_flag   <= 1'b0;
      r_frame_err <= 1'b0;
      if ((r_state == STOP) && w_mid) begin
        if (w_rx) begin
          r_asm <= w_asm_next;
          if (r_byte_cnt == 6'd31) begin
            r_byte_cnt <= '0;
            r_po_data  <= w_asm_next;
            r_po_flag  <= 1'b1;
          end else begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end else begin
          r_byte_cnt  <= '0;
          r_frame_err <= 1'b1;
        end
      end
`ifdef UART_RX_TIMEOUT_EN
      if (w_timeout) begin
        r_byte_cnt  <= '0;
        r_frame_err <= 1'b1;
      end
`endif
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != IDLE) || (r_byte_cnt == '0) || w_fall || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`endif

  assign po_data   = r_po_data;
  assign po_flag   = r_po_flag;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 10 clocks per bit; frame expectations are built by the bench.
module tb_uart_rx_frame;

  logic         clk;
  logic         rst_n;
  logic         rx;
  logic [255:0] po_data;
  logic         po_flag;
  logic         frame_err;

  int checks = 0;
  int fails  = 0;

  int flag_cnt = 0, err_cnt = 0, flag_run = 0, err_run = 0;
  int flag_wide = 0, err_wide = 0, both_cnt = 0, bad_change = 0;
  logic [255:0] cap_data = '0;
  logic [255:0] prev_data = '0;
  int f0, e0, t_err;

  uart_rx_frame #(
    .UART_BPS    (100_000),
    .CLK_FREQ    (1_000_000),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (po_flag && frame_err) both_cnt++;
    if (po_flag) begin
      flag_run++;
      if (flag_run == 1) begin
        flag_cnt++;
        cap_data = po_data;
      end else flag_wide++;
    end else flag_run = 0;
    if (frame_err) begin
      err_run++;
      if (err_run == 1) err_cnt++;
      else err_wide++;
    end else err_run = 0;
    if (rst_n && (po_data !== prev_data) && !po_flag) bad_change++;
    prev_data = po_data;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input int first, input int count, input int base, input int step);
    for (int k = first; k < first + count; k++) send_byte(8'(base + k * step), 1'b1);
  endtask

  function automatic logic [255:0] frame_of(input int base, input int step);
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 32; k++) f[255 - 8 * k -: 8] = 8'(base + k * step);
    return f;
  endfunction

  initial begin
    rx    = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_po_data", po_data, '0);
    chk("reset_po_flag", {255'b0, po_flag}, 256'd0);
    chk("reset_frame_err", {255'b0, frame_err}, 256'd0);
    rst_n = 1'b1;
    idle(10);

    // Incrementing frame 0x00..0x1F
    f0 = flag_cnt; e0 = err_cnt;
    send_seq(0, 32, 0, 1);
    idle(20);
    chk("inc_flag_count", 256'(flag_cnt - f0), 256'd1);
    chk("inc_err_count", 256'(err_cnt - e0), 256'd0);
    chk("inc_first_byte", {248'b0, cap_data[255:248]}, 256'h00);
    chk("inc_last_byte", {248'b0, cap_data[7:0]}, 256'h1F);
    chk("inc_frame", cap_data, frame_of(0, 1));

    // Short low glitch on idle line
    f0 = flag_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(30);
    chk("glitch_flag_count", 256'(flag_cnt - f0), 256'd0);
    chk("glitch_err_count", 256'(err_cnt - e0), 256'd0);
    f0 = flag_cnt;
    send_seq(0, 32, 3, 7);
    idle(20);
    chk("post_glitch_flag", 256'(flag_cnt - f0), 256'd1);
    chk("post_glitch_frame", cap_data, frame_of(3, 7));

    // Bad stop bit on byte 6
    f0 = flag_cnt; e0 = err_cnt;
    send_seq(0, 5, 8'h11, 0);
    send_byte(8'hA5, 1'b0);
    idle(20);
    chk("stoperr_err_count", 256'(err_cnt - e0), 256'd1);
    chk("stoperr_flag_count", 256'(flag_cnt - f0), 256'd0);
    f0 = flag_cnt; e0 = err_cnt;
    send_seq(0, 32, 8'h5A, 0);
    idle(20);
    chk("post_err_flag", 256'(flag_cnt - f0), 256'd1);
    chk("post_err_frame", cap_data, {32{8'h5A}});
    chk("post_err_no_err", 256'(err_cnt - e0), 256'd0);

    // Reset during bit 4 of byte 10
    send_seq(0, 10, 8'h33, 0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h33 >> i));
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    chk("midreset_po_data", po_data, '0);
    chk("midreset_po_flag", {255'b0, po_flag}, 256'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
    f0 = flag_cnt; e0 = err_cnt;
    send_seq(0, 32, 8'hFF, 0);
    idle(20);
    chk("post_reset_flag", 256'(flag_cnt - f0), 256'd1);
    chk("post_reset_frame", cap_data, {256{1'b1}});
    chk("post_reset_no_err", 256'(err_cnt - e0), 256'd0);

    // Partial frame then long idle
    f0 = flag_cnt; e0 = err_cnt;
    send_seq(0, 7, 8'h70, 1);
    t_err = 0;
    for (int i = 1; i <= 250; i++) begin
      @(posedge clk);
      #1;
      if (frame_err && (t_err == 0)) t_err = i;
    end
`ifdef UART_RX_TIMEOUT_EN
    chk("timeout_err_count", 256'(err_cnt - e0), 256'd1);
    chk("timeout_err_cycle", 256'(t_err), 256'd199);
    chk("timeout_no_flag", 256'(flag_cnt - f0), 256'd0);
    f0 = flag_cnt;
    send_seq(0, 32, 8'h70, 1);
`else
    chk("no_timeout_err", 256'(err_cnt - e0), 256'd0);
    chk("no_timeout_no_flag", 256'(flag_cnt - f0), 256'd0);
    send_seq(7, 25, 8'h70, 1);
`endif
    idle(20);
    chk("idle_frame_flag", 256'(flag_cnt - f0), 256'd1);
    chk("idle_frame_data", cap_data, frame_of(8'h70, 1));

    chk("flag_err_overlap", 256'(both_cnt), 256'd0);
    chk("flag_pulse_width", 256'(flag_wide), 256'd0);
    chk("err_pulse_width", 256'(err_wide), 256'd0);
    chk("po_data_hold", 256'(bad_change), 256'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
